// File: rtl/sm3_msg_expand.sv
// SM3 message expansion: turns one 512-bit padded block into the 64 round words W_j / W'_j,
// streamed to the compression rounds over a valid/ready handshake.
module sm3_msg_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [511:0] messageBlock,
    output logic         ready,
    output logic         wValid,
    input  logic         wReady,
    output logic [5:0]   round,
    output logic [31:0]  w,
    output logic [31:0]  wPrime,
    output logic         done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [5:0]  round_q, round_d;
    logic        done_q, done_d;
    logic        xfer;
    logic [31:0] next_word;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl(x, 15) ^ rotl(x, 23);
    endfunction

    // The window always holds W_j..W_(j+15); shifting appends W_(j+16).
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        done_d    = 1'b0;
        win_d     = win_q;
        xfer      = (state_q == ST_RUN) && wReady;
        next_word = p1(win_q[0] ^ win_q[7] ^ rotl(win_q[13], 15))
                    ^ rotl(win_q[3], 7) ^ win_q[10];

        if (state_q == ST_IDLE) begin
            if (start) begin
                // Word 0 occupies the most significant 32 bits of the block.
                for (int k = 0; k < 16; k++) begin
                    win_d[k] = messageBlock[511 - 32*k -: 32];
                end
                round_d = 6'd0;
                state_d = ST_RUN;
            end
        end else begin
            if (xfer) begin
                if (round_q == 6'd63) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    for (int k = 0; k < 15; k++) begin
                        win_d[k] = win_q[k + 1];
                    end
                    win_d[15] = next_word;
                    round_d   = round_q + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= 6'd0;
            done_q  <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            done_q  <= done_d;
            win_q   <= win_d;
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign wValid = (state_q == ST_RUN);
    assign round  = round_q;
    assign w      = win_q[0];
    assign wPrime = win_q[0] ^ win_q[4];
    assign done   = done_q;

endmodule

// File: tb/tb_sm3_msg_expand.sv
// Directed bench for sm3_msg_expand: "abc" and all-ones blocks, stalls, ignored start,
// back-to-back blocks and mid-run reset, checked against a reference W_j table.
module tb_sm3_msg_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [511:0] message_block;
    logic         ready;
    logic         wValid;
    logic         wReady;
    logic [5:0]   round;
    logic [31:0]  w;
    logic [31:0]  wPrime;
    logic         done;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] gold [0:67];

    localparam logic [511:0] ABC_BLOCK  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] ONES_BLOCK = {512{1'b1}};

    sm3_msg_expand dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .messageBlock (message_block),
        .ready        (ready),
        .wValid       (wValid),
        .wReady       (wReady),
        .round        (round),
        .w            (w),
        .wPrime       (wPrime),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] ref_p1(input logic [31:0] x);
        return x ^ ref_rotl(x, 15) ^ ref_rotl(x, 23);
    endfunction

    // Reference expansion in the textbook index form W_j from W_(j-16..j-3).
    task automatic buildGolden(input logic [511:0] blk);
        for (int k = 0; k < 16; k++) begin
            gold[k] = blk[511 - 32*k -: 32];
        end
        for (int j = 16; j < 68; j++) begin
            gold[j] = ref_p1(gold[j-16] ^ gold[j-9] ^ ref_rotl(gold[j-3], 15))
                      ^ ref_rotl(gold[j-13], 7) ^ gold[j-6];
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " ready"},  {31'd0, ready},  32'd1);
        checkOutput({tag, " wValid"}, {31'd0, wValid}, 32'd0);
        checkOutput({tag, " done"},   {31'd0, done},   32'd0);
        checkOutput({tag, " round"},  {26'd0, round},  32'd0);
        checkOutput({tag, " w"},      w,               32'd0);
        checkOutput({tag, " wPrime"}, wPrime,          32'd0);
    endtask

    // Called at posedge+1 in IDLE; leaves the bench at posedge+1 showing round 0.
    task automatic applyStimulus(input logic [511:0] blk);
        message_block = blk;
        start         = 1'b1;
        buildGolden(blk);
        @(posedge clk); #1;
        start         = 1'b0;
        message_block = ~blk;
        checkOutput("latency wValid", {31'd0, wValid}, 32'd1);
    endtask

    task automatic consumeBlock(input string name, input bit stall, input bit poke20,
                                input int abort_at, input int hand, input bit chain,
                                input logic [511:0] next_blk);
        int  t = 0;
        int  cycles = 0;
        bit  poked = 1'b0;
        bit  rdy;
        while (t < 64 && cycles < 1000) begin
            checkOutput($sformatf("%s wValid%0d", name, t), {31'd0, wValid}, 32'd1);
            checkOutput($sformatf("%s round%0d", name, t),  {26'd0, round},  t);
            checkOutput($sformatf("%s w%0d", name, t),      w,      gold[t]);
            checkOutput($sformatf("%s wPrime%0d", name, t), wPrime, gold[t] ^ gold[t+4]);
            checkOutput($sformatf("%s done%0d", name, t),   {31'd0, done},   32'd0);
            if (hand == 1 && t == 0) begin
                checkOutput("abc hand w0",       w,      32'h61626380);
                checkOutput("abc hand wPrime0",  wPrime, 32'h61626380);
            end
            if (hand == 1 && t == 12) begin
                checkOutput("abc hand w12",      w,      32'h00000000);
                checkOutput("abc hand wPrime12", wPrime, 32'h9092e200);
            end
            if (hand == 1 && t == 16) checkOutput("abc hand w16", w, 32'h9092e200);
            if (hand == 1 && t == 18) checkOutput("abc hand w18", w, 32'h000c0606);
            if (hand == 2 && t == 16) checkOutput("ones hand w16", w, 32'hffffffff);

            if (t == abort_at) begin
                rst_n = 1'b0;
                #1;
                checkResetOutputs({name, " in reset"});
                @(posedge clk); #1;
                checkOutput({name, " reset no done"}, {31'd0, done}, 32'd0);
                rst_n = 1'b1;
                @(posedge clk); #1;
                checkResetOutputs({name, " after release"});
                wReady = 1'b0;
                return;
            end

            if (poke20 && t == 20 && !poked) begin
                start         = 1'b1;
                message_block = {16{$urandom()}};
                poked         = 1'b1;
            end else begin
                start = 1'b0;
            end
            rdy    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wReady = rdy;
            @(posedge clk); #1;
            if (rdy) t++;
            cycles++;
        end
        start  = 1'b0;
        wReady = 1'b0;
        checkOutput({name, " transfers"}, t, 64);
        checkOutput({name, " done pulse"}, {31'd0, done},   32'd1);
        checkOutput({name, " done ready"}, {31'd0, ready},  32'd1);
        checkOutput({name, " done wValid"}, {31'd0, wValid}, 32'd0);
        if (chain) begin
            applyStimulus(next_blk);
        end else begin
            @(posedge clk); #1;
            checkOutput({name, " idle ready"}, {31'd0, ready}, 32'd1);
        end
        checkOutput({name, " done once"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        wReady        = 1'b0;
        message_block = '0;
        #12;
        checkResetOutputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkResetOutputs("post release");

        wReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        wReady = 1'b0;
        checkOutput("idle wReady ready",  {31'd0, ready},  32'd1);
        checkOutput("idle wReady wValid", {31'd0, wValid}, 32'd0);
        checkOutput("idle wReady round",  {26'd0, round},  32'd0);

        $display("[TB] abc block, no stalls");
        applyStimulus(ABC_BLOCK);
        consumeBlock("abc", 1'b0, 1'b0, -1, 1, 1'b0, '0);

        $display("[TB] abc block with stalls and stray start, chained into all-ones block");
        applyStimulus(ABC_BLOCK);
        consumeBlock("abc_stall", 1'b1, 1'b1, -1, 0, 1'b1, ONES_BLOCK);
        consumeBlock("ones", 1'b1, 1'b0, -1, 2, 1'b0, '0);

        $display("[TB] reset at round 30, then fresh block");
        applyStimulus(ABC_BLOCK);
        consumeBlock("abort", 1'b0, 1'b0, 30, 0, 1'b0, '0);
        applyStimulus(ABC_BLOCK);
        consumeBlock("fresh", 1'b0, 1'b0, -1, 1, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
